// File: rtl/hls_phi_add_unit_if.sv
// hls_phi_add_unit_if
//   Groups the datapath signals of hls_phi_add_unit: adder operands/result,
//   branch event and recorded block, phi pairs and selection result.
//   master : the generated controller / pipeline side (drives operands,
//            branch events and phi pairs; observes results).
//   slave  : the hls_phi_add_unit itself.
interface hls_phi_add_unit_if #(
  parameter int WIDTH     = 32,
  parameter int PHI_WIDTH = 8,
  parameter int NB_PAIR   = 2,
  parameter int BB_WIDTH  = 32
);
  logic [WIDTH-1:0]              add_in0;
  logic [WIDTH-1:0]              add_in1;
  logic [WIDTH-1:0]              add_out;
  logic                          add_cout;
  logic                          br_valid;
  logic [BB_WIDTH-1:0]           br_src_bb;
  logic [BB_WIDTH-1:0]           last_block;
  logic [NB_PAIR*PHI_WIDTH-1:0]  phi_in;
  logic [NB_PAIR*BB_WIDTH-1:0]   phi_s;
  logic [PHI_WIDTH-1:0]          phi_out;
  logic                          phi_hit;

  modport master (
    output add_in0, add_in1, br_valid, br_src_bb, phi_in, phi_s,
    input  add_out, add_cout, last_block, phi_out, phi_hit
  );

  modport slave (
    input  add_in0, add_in1, br_valid, br_src_bb, phi_in, phi_s,
    output add_out, add_cout, last_block, phi_out, phi_hit
  );
endinterface

// File: rtl/hls_phi_add_unit.sv
// hls_phi_add_unit
//   HLS datapath primitive bundle for generated kernels:
//   - adder : combinational WIDTH-bit add with carry out
//   - br    : records the id of the basic block most recently branched from
//   - phi   : selects the incoming value whose block id matches that record
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous, active-low reset (clears last_block)
//   bus  : hls_phi_add_unit_if.slave
//          add_in0/add_in1 -> add_out/add_cout
//          br_valid/br_src_bb -> last_block (one-cycle latency)
//          phi_in/phi_s + last_block -> phi_out/phi_hit
module hls_phi_add_unit #(
  parameter int WIDTH     = 32,
  parameter int PHI_WIDTH = 8,
  parameter int NB_PAIR   = 2,
  parameter int BB_WIDTH  = 32
) (
  input logic               clk,
  input logic               rst,
  hls_phi_add_unit_if.slave bus
);

  // Adder: one extra bit captures the unsigned carry.
  logic [WIDTH:0] sum_full;

  assign sum_full     = {1'b0, bus.add_in0} + {1'b0, bus.add_in1};
  assign bus.add_out  = sum_full[WIDTH-1:0];
  assign bus.add_cout = sum_full[WIDTH];

  // Branch tracker: the only state in the block.
  logic [BB_WIDTH-1:0] last_block_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_block_q <= '0;
    end else if (bus.br_valid) begin
      last_block_q <= bus.br_src_bb;
    end
  end

  assign bus.last_block = last_block_q;

  // Phi selector: scan from the highest pair down so that the lowest
  // matching index is the last one written and therefore wins.
  logic [PHI_WIDTH-1:0] phi_out_c;
  logic                 phi_hit_c;

  always_comb begin
    phi_out_c = '0;
    phi_hit_c = 1'b0;
    for (int i = NB_PAIR - 1; i >= 0; i--) begin
      if (bus.phi_s[i*BB_WIDTH +: BB_WIDTH] == last_block_q) begin
        phi_out_c = bus.phi_in[i*PHI_WIDTH +: PHI_WIDTH];
        phi_hit_c = 1'b1;
      end
    end
  end

  assign bus.phi_out = phi_out_c;
  assign bus.phi_hit = phi_hit_c;

endmodule

// File: tb/tb_hls_phi_add_unit.sv
// tb_hls_phi_add_unit
//   Directed and randomized bench for hls_phi_add_unit. Two instances are
//   checked side by side: NB_PAIR=2 and NB_PAIR=3. Expected values come from
//   a behavioural model: plain arithmetic for the adder, a remembered block id
//   for the branch tracker and a first-match search for the phi.
module tb_hls_phi_add_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hls_phi_add_unit_if #(.NB_PAIR(2)) bus2 ();
  hls_phi_add_unit_if #(.NB_PAIR(3)) bus3 ();

  hls_phi_add_unit #(.NB_PAIR(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  hls_phi_add_unit #(.NB_PAIR(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int vectors     = 0;
  int miscompares = 0;

  // Model state: block id each instance should currently be holding.
  logic [31:0] lb2 = '0;
  logic [31:0] lb3 = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value of the first pair whose id equals lb; bit 8 flags a hit.
  function automatic logic [8:0] phi_ref(input int n, input logic [23:0] vals,
                                          input logic [95:0] ids, input logic [31:0] lb);
    for (int i = 0; i < n; i++) begin
      if (ids[i*32 +: 32] == lb) return {1'b1, vals[i*8 +: 8]};
    end
    return 9'h000;
  endfunction

  task automatic check_all(input string tag);
    logic [32:0] s2, s3;
    logic [8:0]  p2, p3;
    s2 = {1'b0, bus2.add_in0} + {1'b0, bus2.add_in1};
    s3 = {1'b0, bus3.add_in0} + {1'b0, bus3.add_in1};
    p2 = phi_ref(2, {8'h00, bus2.phi_in}, {32'h0, bus2.phi_s}, lb2);
    p3 = phi_ref(3, bus3.phi_in, bus3.phi_s, lb3);
    chk({tag, ".add2"},  {bus2.add_cout, bus2.add_out}, s2);
    chk({tag, ".add3"},  {bus3.add_cout, bus3.add_out}, s3);
    chk({tag, ".lb2"},   bus2.last_block, lb2);
    chk({tag, ".lb3"},   bus3.last_block, lb3);
    chk({tag, ".phi2"},  {bus2.phi_hit, bus2.phi_out}, p2);
    chk({tag, ".phi3"},  {bus3.phi_hit, bus3.phi_out}, p3);
  endtask

  // Advance one rising edge, update the model, return 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      if (bus2.br_valid) lb2 = bus2.br_src_bb;
      if (bus3.br_valid) lb3 = bus3.br_src_bb;
    end
    #1;
  endtask

  function automatic logic [31:0] rand_id();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return 32'($urandom_range(0, 3));
  endfunction

  logic [31:0] a_tab [3] = '{32'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
  logic [31:0] b_tab [3] = '{32'd1, 32'd1,         32'd1};
  logic [32:0] r_tab [3] = '{33'd6, 33'h1_0000_0000, 33'h0_8000_0000};

  initial begin
    // Reset held with a branch pending: nothing may be recorded.
    rst            = 1'b0;
    bus2.add_in0   = '0;
    bus2.add_in1   = '0;
    bus2.br_valid  = 1'b1;
    bus2.br_src_bb = 32'd7;
    bus2.phi_in    = {8'h2A, 8'h00};
    bus2.phi_s     = {32'd1, 32'd0};
    bus3.add_in0   = '0;
    bus3.add_in1   = '0;
    bus3.br_valid  = 1'b1;
    bus3.br_src_bb = 32'd7;
    bus3.phi_in    = {8'h33, 8'h22, 8'h11};
    bus3.phi_s     = {32'd3, 32'd3, 32'd3};
    #3;
    tick();
    tick();
    chk("rst_hold.lb", bus2.last_block, 32'd0);
    chk("rst_hold.phi_default", {bus2.phi_hit, bus2.phi_out}, 9'h100);
    check_all("rst_hold");

    rst           = 1'b1;
    bus2.br_valid = 1'b0;
    bus3.br_valid = 1'b0;
    tick();
    chk("rst_release.lb", bus2.last_block, 32'd0);
    check_all("rst_release");

    // Adder boundary cases.
    for (int k = 0; k < 3; k++) begin
      bus2.add_in0 = a_tab[k];
      bus2.add_in1 = b_tab[k];
      #2;
      chk($sformatf("add_dir%0d", k), {bus2.add_cout, bus2.add_out}, r_tab[k]);
      check_all("add_dir");
    end

    // Branch from block 1 selects 0x2A starting the next cycle.
    bus2.br_valid  = 1'b1;
    bus2.br_src_bb = 32'd1;
    #2;
    chk("phi_before_edge", {bus2.phi_hit, bus2.phi_out}, 9'h100);
    tick();
    bus2.br_valid = 1'b0;
    #2;
    chk("phi_after_br1", {bus2.phi_hit, bus2.phi_out}, 9'h12A);
    tick();
    chk("phi_hold_br1", {bus2.phi_hit, bus2.phi_out}, 9'h12A);
    // Value change on the selected pair shows up immediately.
    bus2.phi_in = {8'h77, 8'h00};
    #1;
    chk("phi_in_follow", {bus2.phi_hit, bus2.phi_out}, 9'h177);
    bus2.phi_in = {8'h2A, 8'h00};

    // No match, then back to block 0.
    bus2.br_valid  = 1'b1;
    bus2.br_src_bb = 32'd9;
    tick();
    bus2.br_valid = 1'b0;
    #2;
    chk("phi_nomatch", {bus2.phi_hit, bus2.phi_out}, 9'h000);
    bus2.br_valid  = 1'b1;
    bus2.br_src_bb = 32'd0;
    tick();
    bus2.br_valid = 1'b0;
    #2;
    chk("phi_back0", {bus2.phi_hit, bus2.phi_out}, 9'h100);
    check_all("nomatch");

    // All bits of the id take part in the compare.
    bus2.br_valid  = 1'b1;
    bus2.br_src_bb = 32'h8000_0001;
    tick();
    bus2.br_valid = 1'b0;
    #2;
    chk("phi_msb_id", {bus2.phi_hit, bus2.phi_out}, 9'h000);

    // Duplicate ids: lowest pair wins.
    bus3.br_valid  = 1'b1;
    bus3.br_src_bb = 32'd3;
    tick();
    bus3.br_valid = 1'b0;
    #2;
    chk("phi_priority", {bus3.phi_hit, bus3.phi_out}, 9'h111);
    check_all("priority");

    // Asynchronous reset between edges.
    bus2.phi_in    = {8'h2A, 8'h5C};
    bus2.br_valid  = 1'b1;
    bus2.br_src_bb = 32'd1;
    tick();
    bus2.br_valid = 1'b0;
    #2;
    chk("async_pre", {bus2.phi_hit, bus2.phi_out}, 9'h12A);
    rst = 1'b0;
    lb2 = '0;
    lb3 = '0;
    #1;
    chk("async_lb", bus2.last_block, 32'd0);
    chk("async_phi", {bus2.phi_hit, bus2.phi_out}, 9'h15C);
    check_all("async");
    rst = 1'b1;
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bus2.add_in0   = $urandom;
      bus2.add_in1   = ($urandom_range(0, 3) == 0) ? ~bus2.add_in0 + 32'($urandom_range(0, 2)) : $urandom;
      bus3.add_in0   = $urandom;
      bus3.add_in1   = $urandom;
      bus2.br_valid  = $urandom_range(0, 1) == 1;
      bus3.br_valid  = $urandom_range(0, 1) == 1;
      bus2.br_src_bb = rand_id();
      bus3.br_src_bb = rand_id();
      if ($urandom_range(0, 3) == 0) begin
        bus2.phi_in = 16'($urandom);
        bus2.phi_s  = {rand_id(), rand_id()};
        bus3.phi_in = 24'($urandom);
        bus3.phi_s  = {rand_id(), rand_id(), rand_id()};
      end
      #2;
      check_all("rand_comb");
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b0;
        lb2 = '0;
        lb3 = '0;
        #1;
        check_all("rand_rst");
        rst = 1'b1;
      end
      tick();
      #1;
      check_all("rand_seq");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
